// File: rtl/hough_lane_select.sv
// Hough lane selector: scans a RHO_RANGE x THETAS vote accumulator held in an
// external BRAM (one-cycle read latency). It keeps the strongest line inside
// the left-lane and the right-lane theta windows and reports each line as
// (rho, theta, votes, valid).
//
// Sequencing: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
//   - The start cycle drives address 0.
//   - Every SCAN cycle drives the next address and evaluates the word that the
//     previous address returned. Delayed row/theta registers tag that word.
//   - DRAIN evaluates the last word and loads the outputs.
//   - done pulses in DONE.
// Interface handshake: start is a level request that is sampled only in IDLE.
// done is a one-cycle pulse. The result outputs are stable from done until the
// next scan completes.
module hough_lane_select #(
    parameter int RHO_RANGE      = 1024,
    parameter int THETAS         = 180,
    parameter int LEFT_MIN       = 20,
    parameter int LEFT_MAX       = 70,
    parameter int RIGHT_MIN      = 110,
    parameter int RIGHT_MAX      = 160,
    parameter int VOTE_THRESHOLD = 16,
    localparam int N             = RHO_RANGE * THETAS,
    localparam int AW            = $clog2(N),
    localparam int TW            = $clog2(THETAS),
    localparam int RW            = (RHO_RANGE > 1) ? $clog2(RHO_RANGE) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic [AW-1:0]        accum_bram_rd_addr,
    input  logic [15:0]          accum_bram_rd_data,
    output logic signed [15:0]   left_rho,
    output logic signed [15:0]   right_rho,
    output logic [TW-1:0]        left_theta,
    output logic [TW-1:0]        right_theta,
    output logic [15:0]          left_votes,
    output logic [15:0]          right_votes,
    output logic                 left_valid,
    output logic                 right_valid,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(THETAS - 1);
    localparam logic [TW-1:0] L_MIN     = TW'(LEFT_MIN);
    localparam logic [TW-1:0] L_MAX     = TW'(LEFT_MAX);
    localparam logic [TW-1:0] R_MIN     = TW'(RIGHT_MIN);
    localparam logic [TW-1:0] R_MAX     = TW'(RIGHT_MAX);
    localparam logic [15:0]   RHO_HALF  = 16'(RHO_RANGE / 2);
    localparam logic [15:0]   THRESH    = 16'(VOTE_THRESHOLD);

    state_t           state_q;
    logic [AW-1:0]    addr_q;
    logic [RW-1:0]    row_q, ev_row_q, row_nxt;
    logic [TW-1:0]    theta_q, ev_theta_q, theta_nxt;

    // Running maxima and the row/theta where each maximum was found.
    logic [15:0]      lmax_q, lmax_d, rmax_q, rmax_d;
    logic [RW-1:0]    lrow_q, lrow_d, rrow_q, rrow_d;
    logic [TW-1:0]    ltheta_q, ltheta_d, rtheta_q, rtheta_d;

    // Registered results.
    logic signed [15:0] left_rho_q, right_rho_q;
    logic [TW-1:0]      left_theta_q, right_theta_q;
    logic [15:0]        left_votes_q, right_votes_q;
    logic               left_valid_q, right_valid_q, done_q;

    logic ev_active, in_left, in_right;

    // Converts a row index to a signed rho in 16-bit two's complement.
    function automatic logic signed [15:0] to_rho(input logic [RW-1:0] row);
        logic [15:0] row_ext;
        row_ext = 16'(row);
        return $signed(row_ext - RHO_HALF);
    endfunction

    // Computes the (row, theta) of the next address in row-major order, theta fastest.
    always_comb begin
        theta_nxt = theta_q + 1'b1;
        row_nxt   = row_q;
        if (theta_q == T_LAST) begin
            theta_nxt = '0;
            row_nxt   = row_q + 1'b1;
        end
    end

    // Evaluates the returned word against each window. A strict compare keeps
    // the lowest address when votes tie.
    always_comb begin
        ev_active = (state_q == S_SCAN) || (state_q == S_DRAIN);
        in_left   = (ev_theta_q >= L_MIN) && (ev_theta_q <= L_MAX);
        in_right  = (ev_theta_q >= R_MIN) && (ev_theta_q <= R_MAX);
        lmax_d    = lmax_q;
        lrow_d    = lrow_q;
        ltheta_d  = ltheta_q;
        rmax_d    = rmax_q;
        rrow_d    = rrow_q;
        rtheta_d  = rtheta_q;
        if (ev_active && in_left && (accum_bram_rd_data > lmax_q)) begin
            lmax_d   = accum_bram_rd_data;
            lrow_d   = ev_row_q;
            ltheta_d = ev_theta_q;
        end
        if (ev_active && in_right && (accum_bram_rd_data > rmax_q)) begin
            rmax_d   = accum_bram_rd_data;
            rrow_d   = ev_row_q;
            rtheta_d = ev_theta_q;
        end
    end

    // Scan controller: address generation, tag pipeline, maxima and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            row_q         <= '0;
            theta_q       <= '0;
            ev_row_q      <= '0;
            ev_theta_q    <= '0;
            lmax_q        <= '0;
            lrow_q        <= '0;
            ltheta_q      <= '0;
            rmax_q        <= '0;
            rrow_q        <= '0;
            rtheta_q      <= '0;
            left_rho_q    <= '0;
            right_rho_q   <= '0;
            left_theta_q  <= '0;
            right_theta_q <= '0;
            left_votes_q  <= '0;
            right_votes_q <= '0;
            left_valid_q  <= 1'b0;
            right_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            ev_row_q   <= row_q;
            ev_theta_q <= theta_q;
            lmax_q     <= lmax_d;
            lrow_q     <= lrow_d;
            ltheta_q   <= ltheta_d;
            rmax_q     <= rmax_d;
            rrow_q     <= rrow_d;
            rtheta_q   <= rtheta_d;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    addr_q  <= '0;
                    row_q   <= '0;
                    theta_q <= '0;
                    if (start) begin
                        addr_q   <= addr_q + 1'b1;
                        row_q    <= row_nxt;
                        theta_q  <= theta_nxt;
                        lmax_q   <= '0;
                        lrow_q   <= '0;
                        ltheta_q <= '0;
                        rmax_q   <= '0;
                        rrow_q   <= '0;
                        rtheta_q <= '0;
                        state_q  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (addr_q == ADDR_LAST) begin
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        row_q   <= row_nxt;
                        theta_q <= theta_nxt;
                    end
                end
                S_DRAIN: begin
                    left_rho_q    <= to_rho(lrow_d);
                    left_theta_q  <= ltheta_d;
                    left_votes_q  <= lmax_d;
                    left_valid_q  <= (lmax_d >= THRESH);
                    right_rho_q   <= to_rho(rrow_d);
                    right_theta_q <= rtheta_d;
                    right_votes_q <= rmax_d;
                    right_valid_q <= (rmax_d >= THRESH);
                    done_q        <= 1'b1;
                    state_q       <= S_DONE;
                end
                default: begin
                    addr_q  <= '0;
                    row_q   <= '0;
                    theta_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign accum_bram_rd_addr = addr_q;
    assign left_rho           = left_rho_q;
    assign right_rho          = right_rho_q;
    assign left_theta         = left_theta_q;
    assign right_theta        = right_theta_q;
    assign left_votes         = left_votes_q;
    assign right_votes        = right_votes_q;
    assign left_valid         = left_valid_q;
    assign right_valid        = right_valid_q;
    assign done               = done_q;

endmodule

// File: tb/tb_hough_lane_select.sv
// Directed bench for hough_lane_select. It uses a reduced 16-row accumulator
// so that each scan is short: rho = r - 8 and N = 16*180 = 2880 words.
module tb_hough_lane_select;

    localparam int RHO_RANGE = 16;
    localparam int THETAS    = 180;
    localparam int N         = RHO_RANGE * THETAS;
    localparam int AW        = $clog2(N);
    localparam int TW        = $clog2(THETAS);

    logic                clock;
    logic                reset;
    logic                start;
    logic [AW-1:0]       accum_bram_rd_addr;
    logic [15:0]         accum_bram_rd_data;
    logic signed [15:0]  left_rho, right_rho;
    logic [TW-1:0]       left_theta, right_theta;
    logic [15:0]         left_votes, right_votes;
    logic                left_valid, right_valid, done;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:N-1];

    hough_lane_select #(
        .RHO_RANGE(RHO_RANGE),
        .THETAS(THETAS),
        .LEFT_MIN(20),
        .LEFT_MAX(70),
        .RIGHT_MIN(110),
        .RIGHT_MAX(160),
        .VOTE_THRESHOLD(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .accum_bram_rd_addr(accum_bram_rd_addr),
        .accum_bram_rd_data(accum_bram_rd_data),
        .left_rho(left_rho),
        .right_rho(right_rho),
        .left_theta(left_theta),
        .right_theta(right_theta),
        .left_votes(left_votes),
        .right_votes(right_votes),
        .left_valid(left_valid),
        .right_valid(right_valid),
        .done(done)
    );

    // Clock and BRAM model with one-cycle read latency.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) accum_bram_rd_data <= mem[accum_bram_rd_addr];

    task automatic clear_mem();
        for (int i = 0; i < N; i++) mem[i] = 16'd0;
    endtask

    task automatic set_cell(input int r, input int t, input logic [15:0] v);
        mem[r * THETAS + t] = v;
    endtask

    // Starts one scan, with the start cycle as cycle 0, and follows it for
    // N+4 cycles. It records the first done cycle, the number of done pulses
    // and the number of address mismatches. The expected address is
    // min(k, N-1) up to DONE and 0 afterwards.
    task automatic run_scan(input bit hold, output int done_cycle, output int ndone,
                            output int addr_bad);
        int exp_addr;
        done_cycle = -1;
        ndone      = 0;
        addr_bad   = 0;
        @(posedge clock); #1;
        start = 1'b1;
        if (accum_bram_rd_addr !== AW'(0)) addr_bad++;
        for (int k = 1; k <= N + 4; k++) begin
            @(posedge clock); #1;
            if (!hold) start = 1'b0;
            if (k <= N + 1) exp_addr = (k <= N - 1) ? k : N - 1;
            else exp_addr = 0;
            if (accum_bram_rd_addr !== AW'(exp_addr)) addr_bad++;
            if (done === 1'b1) begin
                ndone++;
                if (done_cycle < 0) done_cycle = k;
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++;
        if (accum_bram_rd_addr !== AW'(0)) begin
            errors++; $display("FAIL reset_addr got %0d exp 0", accum_bram_rd_addr);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b exp 0", done);
        end
        checks++;
        if (left_votes !== 16'd0 || right_votes !== 16'd0) begin
            errors++; $display("FAIL reset_votes got %0d/%0d exp 0/0", left_votes, right_votes);
        end
        checks++;
        if (left_valid !== 1'b0 || right_valid !== 1'b0 || left_rho !== 16'sd0) begin
            errors++; $display("FAIL reset_outs got v=%b%b rho=%0d exp 00 0",
                               left_valid, right_valid, left_rho);
        end
    endtask

    task automatic test_all_zero();
        int dc, nd, ab;
        clear_mem();
        run_scan(1'b0, dc, nd, ab);
        checks++;
        if (dc !== N + 1) begin
            errors++; $display("FAIL zero_done_cycle got %0d exp %0d", dc, N + 1);
        end
        checks++;
        if (nd !== 1) begin
            errors++; $display("FAIL zero_done_count got %0d exp 1", nd);
        end
        checks++;
        if (ab !== 0) begin
            errors++; $display("FAIL zero_addr_seq got %0d bad exp 0", ab);
        end
        checks++;
        if (left_valid !== 1'b0 || right_valid !== 1'b0 || left_votes !== 16'd0 ||
            right_votes !== 16'd0 || left_theta !== TW'(0) || right_theta !== TW'(0)) begin
            errors++; $display("FAIL zero_result got v=%b%b votes=%0d/%0d th=%0d/%0d exp all 0",
                               left_valid, right_valid, left_votes, right_votes,
                               left_theta, right_theta);
        end
        checks++;
        if (left_rho !== -16'sd8 || right_rho !== -16'sd8) begin
            errors++; $display("FAIL zero_rho got %0d/%0d exp -8/-8", left_rho, right_rho);
        end
    endtask

    task automatic test_single_peaks();
        int dc, nd, ab;
        clear_mem();
        set_cell(12, 45, 16'd40);
        set_cell(3, 135, 16'd30);
        run_scan(1'b0, dc, nd, ab);
        checks++;
        if (dc !== N + 1) begin
            errors++; $display("FAIL peaks_done_cycle got %0d exp %0d", dc, N + 1);
        end
        checks++;
        if (left_rho !== 16'sd4 || left_theta !== TW'(45) || left_votes !== 16'd40 ||
            left_valid !== 1'b1) begin
            errors++; $display("FAIL peaks_left got rho=%0d th=%0d v=%0d ok=%b exp 4 45 40 1",
                               left_rho, left_theta, left_votes, left_valid);
        end
        checks++;
        if (right_rho !== -16'sd5 || right_theta !== TW'(135) || right_votes !== 16'd30 ||
            right_valid !== 1'b1) begin
            errors++; $display("FAIL peaks_right got rho=%0d th=%0d v=%0d ok=%b exp -5 135 30 1",
                               right_rho, right_theta, right_votes, right_valid);
        end
        repeat (6) @(posedge clock);
        #1;
        checks++;
        if (left_votes !== 16'd40 || right_theta !== TW'(135) || done !== 1'b0) begin
            errors++; $display("FAIL peaks_hold got lv=%0d rth=%0d done=%b exp 40 135 0",
                               left_votes, right_theta, done);
        end
    endtask

    task automatic test_tie();
        int dc, nd, ab;
        clear_mem();
        set_cell(1, 30, 16'd50);
        set_cell(14, 60, 16'd50);
        set_cell(2, 110, 16'd16);
        set_cell(2, 160, 16'd16);
        run_scan(1'b0, dc, nd, ab);
        checks++;
        if (left_rho !== -16'sd7 || left_theta !== TW'(30) || left_votes !== 16'd50) begin
            errors++; $display("FAIL tie_left got rho=%0d th=%0d v=%0d exp -7 30 50",
                               left_rho, left_theta, left_votes);
        end
        checks++;
        if (right_rho !== -16'sd6 || right_theta !== TW'(110) || right_valid !== 1'b1) begin
            errors++; $display("FAIL tie_right_thresh got rho=%0d th=%0d ok=%b exp -6 110 1",
                               right_rho, right_theta, right_valid);
        end
    endtask

    task automatic test_outside_windows();
        int dc, nd, ab;
        clear_mem();
        set_cell(7, 90, 16'd200);
        set_cell(9, 50, 16'd10);
        run_scan(1'b0, dc, nd, ab);
        checks++;
        if (left_votes !== 16'd10 || left_theta !== TW'(50) || left_rho !== 16'sd1 ||
            left_valid !== 1'b0) begin
            errors++; $display("FAIL outside_left got v=%0d th=%0d rho=%0d ok=%b exp 10 50 1 0",
                               left_votes, left_theta, left_rho, left_valid);
        end
        checks++;
        if (right_valid !== 1'b0 || right_votes !== 16'd0 || right_theta !== TW'(0)) begin
            errors++; $display("FAIL outside_right got ok=%b v=%0d th=%0d exp 0 0 0",
                               right_valid, right_votes, right_theta);
        end
    endtask

    task automatic test_window_edges();
        int dc, nd, ab;
        clear_mem();
        set_cell(4, 19, 16'd300);
        set_cell(4, 70, 16'd17);
        set_cell(4, 71, 16'd300);
        set_cell(6, 109, 16'd500);
        set_cell(15, 160, 16'hFFFF);
        set_cell(15, 161, 16'd900);
        run_scan(1'b0, dc, nd, ab);
        checks++;
        if (left_votes !== 16'd17 || left_theta !== TW'(70) || left_rho !== -16'sd4 ||
            left_valid !== 1'b1) begin
            errors++; $display("FAIL edge_left got v=%0d th=%0d rho=%0d ok=%b exp 17 70 -4 1",
                               left_votes, left_theta, left_rho, left_valid);
        end
        checks++;
        if (right_votes !== 16'hFFFF || right_theta !== TW'(160) || right_rho !== 16'sd7 ||
            right_valid !== 1'b1) begin
            errors++; $display("FAIL edge_right_max got v=%0h th=%0d rho=%0d ok=%b exp ffff 160 7 1",
                               right_votes, right_theta, right_rho, right_valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        int dc, nd, ab, stray;
        clear_mem();
        set_cell(12, 45, 16'd40);
        set_cell(3, 135, 16'd30);
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (500) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (accum_bram_rd_addr !== AW'(0) || done !== 1'b0) begin
            errors++; $display("FAIL midrst_idle got addr=%0d done=%b exp 0 0",
                               accum_bram_rd_addr, done);
        end
        checks++;
        if (left_votes !== 16'd0 || left_rho !== 16'sd0 || right_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_outs got lv=%0d lrho=%0d rok=%b exp 0 0 0",
                               left_votes, left_rho, right_valid);
        end
        stray = 0;
        for (int k = 0; k < N + 5; k++) begin
            @(posedge clock); #1;
            if (done === 1'b1) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL midrst_no_done got %0d pulses exp 0", stray);
        end
        run_scan(1'b0, dc, nd, ab);
        checks++;
        if (dc !== N + 1 || nd !== 1) begin
            errors++; $display("FAIL midrst_rescan_done got cycle=%0d n=%0d exp %0d 1",
                               dc, nd, N + 1);
        end
        checks++;
        if (left_rho !== 16'sd4 || left_votes !== 16'd40 || right_rho !== -16'sd5 ||
            right_votes !== 16'd30) begin
            errors++; $display("FAIL midrst_rescan_res got %0d/%0d %0d/%0d exp 4/40 -5/30",
                               left_rho, left_votes, right_rho, right_votes);
        end
    endtask

    task automatic test_start_held();
        int dc, nd, ab;
        clear_mem();
        set_cell(0, 20, 16'd15);
        set_cell(8, 120, 16'd99);
        run_scan(1'b1, dc, nd, ab);
        checks++;
        if (dc !== N + 1 || nd !== 1) begin
            errors++; $display("FAIL held_done got cycle=%0d n=%0d exp %0d 1", dc, nd, N + 1);
        end
        checks++;
        if (ab !== 0) begin
            errors++; $display("FAIL held_addr_seq got %0d bad exp 0", ab);
        end
        checks++;
        if (left_votes !== 16'd15 || left_valid !== 1'b0 || left_theta !== TW'(20) ||
            right_rho !== 16'sd0 || right_votes !== 16'd99) begin
            errors++; $display("FAIL held_result got lv=%0d lok=%b lth=%0d rrho=%0d rv=%0d exp 15 0 20 0 99",
                               left_votes, left_valid, left_theta, right_rho, right_votes);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_mem();
        test_reset();
        test_all_zero();
        test_single_peaks();
        test_tie();
        test_outside_windows();
        test_window_edges();
        test_reset_mid_scan();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
